hub75_bcm_scan: RTL and testbench

Parametrised HUB75 scan engine that replaces the fixed 32-column, 1/16-scan, comparator-PWM pixel sequencer and the top-level colour comparators with one block. It reads dual-half pixel words from the frame RAM. It drives the panel using binary-coded modulation (BCM) with configurable width, scan depth and colour depth. It double-buffers frames with a swap handshake so the SPI writer can fill one buffer while the other is displayed.

---
 rtl/hub75_bcm_scan_pkg.sv | 29 ++
 rtl/hub75_bcm_scan_if.sv | 40 ++++
 rtl/hub75_bcm_scan_plane_timer.sv | 37 +++
 rtl/hub75_bcm_scan.sv | 197 +++++++++++++++++++
 tb/tb_hub75_bcm_scan.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hub75_bcm_scan_pkg.sv
// Shared definitions for the HUB75 BCM scan engine: FSM encodings, pixel
// channel layout and the RAM read-address field order.
package hub75_bcm_scan_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREFETCH = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_LATCH    = 3'd3;
    localparam logic [2:0] ST_DISPLAY  = 3'd4;

    // Pixel word is {r,g,b}, each DEPTH bits, r in the MSBs.
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    typedef struct packed {
        logic r1;
        logic g1;
        logic b1;
        logic r2;
        logic g2;
        logic b2;
    } hub_rgb_t;

    function automatic int ch_lsb(input int ch, input int depth);
        return ch * depth;
    endfunction

endpackage

// File: rtl/hub75_bcm_scan_if.sv
// Bus bundle between the scan engine, its control/frame RAM side and the panel.
interface hub75_bcm_scan_if #(
    parameter int WIDTH    = 32,
    parameter int ROW_BITS = 4,
    parameter int DEPTH    = 5
);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int PIX_W  = 3 * DEPTH;
    localparam int ADDR_W = 1 + ROW_BITS + COL_W;

    logic                enable;
    logic                swap_req;
    logic                swap_ack;
    logic                frame_done;
    logic                buf_sel;
    logic [ADDR_W-1:0]   ram_raddr;
    logic [PIX_W-1:0]    ram_rdata_top;
    logic [PIX_W-1:0]    ram_rdata_bot;
    logic                hub_r1, hub_g1, hub_b1;
    logic                hub_r2, hub_g2, hub_b2;
    logic                hub_clk;
    logic                hub_lat;
    logic                hub_oe;
    logic [ROW_BITS-1:0] hub_row;

    modport master (
        input  enable, swap_req, ram_rdata_top, ram_rdata_bot,
        output swap_ack, frame_done, buf_sel, ram_raddr,
               hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
               hub_clk, hub_lat, hub_oe, hub_row
    );

    modport slave (
        output enable, swap_req, ram_rdata_top, ram_rdata_bot,
        input  swap_ack, frame_done, buf_sel, ram_raddr,
               hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
               hub_clk, hub_lat, hub_oe, hub_row
    );

endinterface

// File: rtl/hub75_bcm_scan_plane_timer.sv
// Down-counting DISPLAY timer: loaded with BASE_TIME<<plane, flags the last cycle.
module hub75_bcm_scan_plane_timer #(
    parameter int  BASE_TIME = 4,
    parameter int  DEPTH     = 5,
    localparam int PL_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [PL_W-1:0] plane_i,
    output logic            expired_o
);
    localparam int CNT_W = $clog2(BASE_TIME) + DEPTH;

    logic [CNT_W-1:0] count_q, count_d;

    // Loaded with length-1 so that zero marks the final DISPLAY cycle.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (CNT_W'(BASE_TIME) << plane_i) - CNT_W'(1);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 binary-coded-modulation scan engine with double-buffered frame swap.
// state    | meaning
// IDLE     | panel blanked, waiting for enable
// PREFETCH | col 0 address presented to frame RAM
// SHIFT    | two cycles per column: data set up, then hub_clk high
// LATCH    | latch shifted row, update row address
// DISPLAY  | OE active for BASE_TIME<<plane cycles
module hub75_bcm_scan
    import hub75_bcm_scan_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ROW_BITS  = 4,
    parameter int DEPTH     = 5,
    parameter int BASE_TIME = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hub75_bcm_scan_if.master bus
);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int PL_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ADDR_W = 1 + ROW_BITS + COL_W;
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
    localparam logic [PL_W-1:0]  PLANE_LAST = PL_W'(DEPTH - 1);

    logic [2:0]          state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                phase_q, phase_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    hub_rgb_t            rgb_q, rgb_d;
    logic [ROW_BITS-1:0] hub_row_q, hub_row_d;
    logic                buf_sel_q, buf_sel_d;
    logic                hub_clk_q, hub_clk_d;
    logic                hub_lat_q, hub_lat_d;
    logic                hub_oe_q, hub_oe_d;
    logic                frame_done_q, frame_done_d;
    logic                swap_ack_q, swap_ack_d;
    logic                disp_expired;

    logic [DEPTH-1:0] r_top, g_top, b_top, r_bot, g_bot, b_bot;

    assign r_top = bus.ram_rdata_top[ch_lsb(CH_R, DEPTH) +: DEPTH];
    assign g_top = bus.ram_rdata_top[ch_lsb(CH_G, DEPTH) +: DEPTH];
    assign b_top = bus.ram_rdata_top[ch_lsb(CH_B, DEPTH) +: DEPTH];
    assign r_bot = bus.ram_rdata_bot[ch_lsb(CH_R, DEPTH) +: DEPTH];
    assign g_bot = bus.ram_rdata_bot[ch_lsb(CH_G, DEPTH) +: DEPTH];
    assign b_bot = bus.ram_rdata_bot[ch_lsb(CH_B, DEPTH) +: DEPTH];

    function automatic logic [ADDR_W-1:0] mk_addr(input logic b,
                                                  input logic [ROW_BITS-1:0] r,
                                                  input logic [COL_W-1:0] c);
        return {b, r, c};
    endfunction

    hub75_bcm_scan_plane_timer #(
        .BASE_TIME (BASE_TIME),
        .DEPTH     (DEPTH)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (state_q == ST_LATCH),
        .plane_i   (plane_q),
        .expired_o (disp_expired)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        col_d        = col_q;
        phase_d      = phase_q;
        raddr_d      = raddr_q;
        rgb_d        = rgb_q;
        hub_row_d    = hub_row_q;
        buf_sel_d    = buf_sel_q;
        hub_clk_d    = 1'b0;
        hub_lat_d    = 1'b0;
        hub_oe_d     = 1'b1;
        frame_done_d = 1'b0;
        swap_ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_PREFETCH;
                    raddr_d = mk_addr(buf_sel_q, row_q, '0);
                end
            end
            ST_PREFETCH: begin
                state_d = ST_SHIFT;
                col_d   = '0;
                phase_d = 1'b0;
                raddr_d = mk_addr(buf_sel_q, row_q, COL_W'(1));
            end
            ST_SHIFT: begin
                // RAM data for col is valid during its phase 0; capture it so it
                // is stable across the hub_clk high phase.
                if (!phase_q) begin
                    phase_d   = 1'b1;
                    hub_clk_d = 1'b1;
                    rgb_d     = '{r1: r_top[plane_q], g1: g_top[plane_q], b1: b_top[plane_q],
                                  r2: r_bot[plane_q], g2: g_bot[plane_q], b2: b_bot[plane_q]};
                end else if (col_q == COL_LAST) begin
                    state_d   = ST_LATCH;
                    phase_d   = 1'b0;
                    hub_lat_d = 1'b1;
                    hub_row_d = row_q;
                end else begin
                    col_d   = col_q + 1'b1;
                    phase_d = 1'b0;
                    raddr_d = mk_addr(buf_sel_q, row_q, col_q + COL_W'(2));
                end
            end
            ST_LATCH: begin
                state_d  = ST_DISPLAY;
                hub_oe_d = 1'b0;
            end
            ST_DISPLAY: begin
                if (!disp_expired) begin
                    hub_oe_d = 1'b0;
                end else if (plane_q != PLANE_LAST) begin
                    plane_d = plane_q + 1'b1;
                    state_d = ST_PREFETCH;
                    raddr_d = mk_addr(buf_sel_q, row_q, '0);
                end else begin
                    plane_d = '0;
                    if (row_q != '1) begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_PREFETCH;
                        raddr_d = mk_addr(buf_sel_q, row_q + 1'b1, '0);
                    end else begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                        if (bus.swap_req) begin
                            buf_sel_d  = ~buf_sel_q;
                            swap_ack_d = 1'b1;
                        end
                        raddr_d = mk_addr(buf_sel_d, '0, '0);
                        state_d = bus.enable ? ST_PREFETCH : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            raddr_q      <= '0;
            rgb_q        <= '0;
            hub_row_q    <= '0;
            buf_sel_q    <= 1'b0;
            hub_clk_q    <= 1'b0;
            hub_lat_q    <= 1'b0;
            hub_oe_q     <= 1'b1;
            frame_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            raddr_q      <= raddr_d;
            rgb_q        <= rgb_d;
            hub_row_q    <= hub_row_d;
            buf_sel_q    <= buf_sel_d;
            hub_clk_q    <= hub_clk_d;
            hub_lat_q    <= hub_lat_d;
            hub_oe_q     <= hub_oe_d;
            frame_done_q <= frame_done_d;
            swap_ack_q   <= swap_ack_d;
        end
    end

    assign bus.swap_ack   = swap_ack_q;
    assign bus.frame_done = frame_done_q;
    assign bus.buf_sel    = buf_sel_q;
    assign bus.ram_raddr  = raddr_q;
    assign bus.hub_r1     = rgb_q.r1;
    assign bus.hub_g1     = rgb_q.g1;
    assign bus.hub_b1     = rgb_q.b1;
    assign bus.hub_r2     = rgb_q.r2;
    assign bus.hub_g2     = rgb_q.g2;
    assign bus.hub_b2     = rgb_q.b2;
    assign bus.hub_clk    = hub_clk_q;
    assign bus.hub_lat    = hub_lat_q;
    assign bus.hub_oe     = hub_oe_q;
    assign bus.hub_row    = hub_row_q;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Scoreboard bench for hub75_bcm_scan at WIDTH=4, ROW_BITS=1, DEPTH=2, BASE_TIME=2
// (12/14 cycles per plane, 26 per row, 52 per frame).
module tb_hub75_bcm_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hub75_bcm_scan_if #(.WIDTH(4), .ROW_BITS(1), .DEPTH(2)) bus ();

    hub75_bcm_scan #(.WIDTH(4), .ROW_BITS(1), .DEPTH(2), .BASE_TIME(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [5:0] mem_top [16];
    logic [5:0] mem_bot [16];

    always @(posedge clk) begin
        bus.ram_rdata_top <= mem_top[bus.ram_raddr];
        bus.ram_rdata_bot <= mem_bot[bus.ram_raddr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic ack;
        logic bsel;
        int   gap;
    } fd_t;

    fd_t        fd_q  [$];
    int         lat_q [$];
    logic [5:0] rgb_q [$];

    function automatic logic [16:0] outs();
        return {bus.hub_oe, bus.hub_clk, bus.hub_lat, bus.hub_row, bus.ram_raddr,
                bus.buf_sel, bus.frame_done, bus.swap_ack,
                bus.hub_r1, bus.hub_g1, bus.hub_b1, bus.hub_r2, bus.hub_g2, bus.hub_b2};
    endfunction

    // Monitor: pops expected responses whenever the DUT presents an event.
    int   mcyc     = 0;
    int   last_fd  = -1;
    logic prev_clk = 1'b0;
    logic prev_row = 1'b0;

    always @(negedge clk) begin
        fd_t f;
        mcyc++;
        if (!rst) begin
            if (bus.hub_lat === 1'b1 && lat_q.size() > 0)
                chk("lat_row", 32'(bus.hub_row), 32'(lat_q.pop_front()));
            if (bus.hub_clk === 1'b1 && prev_clk === 1'b0 && rgb_q.size() > 0)
                chk("rgb_at_clk_rise",
                    {bus.hub_r1, bus.hub_g1, bus.hub_b1, bus.hub_r2, bus.hub_g2, bus.hub_b2},
                    rgb_q.pop_front());
            if (bus.frame_done === 1'b1) begin
                chk("frame_done_expected", 32'(fd_q.size() > 0), 32'd1);
                if (fd_q.size() > 0) begin
                    f = fd_q.pop_front();
                    chk("swap_ack_at_frame_done", bus.swap_ack, f.ack);
                    chk("buf_sel_at_frame_done", bus.buf_sel, f.bsel);
                    if (last_fd >= 0 && f.gap > 0)
                        chk("frame_period", mcyc - last_fd, f.gap);
                end
                last_fd = mcyc;
            end else if (bus.swap_ack !== 1'b0) begin
                chk("swap_ack_without_frame_done", bus.swap_ack, 1'b0);
            end
            if (bus.hub_row !== prev_row)
                chk("row_change_only_in_latch", {bus.hub_oe, bus.hub_lat}, 2'b11);
        end
        prev_clk = bus.hub_clk;
        prev_row = bus.hub_row;
    end

    int first_lat;
    int idle_oe_low;
    int idle_lat;
    int rst_events;
    logic exp_oe, exp_lat;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_top[i] = '0;
            mem_bot[i] = '0;
        end
        mem_top[2] = 6'b11_00_01;
        mem_bot[2] = 6'b00_10_11;
        bus.enable   = 1'b0;
        bus.swap_req = 1'b0;

        for (int f = 0; f < 6; f++) begin
            lat_q.push_back(0); lat_q.push_back(0);
            lat_q.push_back(1); lat_q.push_back(1);
        end
        rgb_q.push_back(6'b000000); rgb_q.push_back(6'b000000);
        rgb_q.push_back(6'b101001); rgb_q.push_back(6'b000000);
        rgb_q.push_back(6'b000000); rgb_q.push_back(6'b000000);
        rgb_q.push_back(6'b100011); rgb_q.push_back(6'b000000);
        fd_q.push_back('{ack: 1'b0, bsel: 1'b0, gap: 0});
        fd_q.push_back('{ack: 1'b1, bsel: 1'b1, gap: 52});
        fd_q.push_back('{ack: 1'b1, bsel: 1'b0, gap: 52});
        fd_q.push_back('{ack: 1'b0, bsel: 1'b0, gap: 52});
        fd_q.push_back('{ack: 1'b0, bsel: 1'b0, gap: 52});

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'h10000);
        rst        = 1'b0;
        bus.enable = 1'b1;
        first_lat  = -1;
        idle_oe_low = 0;
        idle_lat    = 0;
        rst_events  = 0;

        for (int k = 0; k <= 337; k++) begin
            if (k <= 26) begin
                exp_oe  = !((k >= 11 && k <= 12) || (k >= 23 && k <= 26));
                exp_lat = (k == 10) || (k == 22);
                chk($sformatf("oe_k%0d", k), bus.hub_oe, exp_oe);
                chk($sformatf("lat_k%0d", k), bus.hub_lat, exp_lat);
                if (bus.hub_lat === 1'b1 && first_lat < 0) first_lat = k;
            end
            case (k)
                1:   chk("raddr_prefetch", bus.ram_raddr, 4'd0);
                2:   chk("raddr_col0_phase0", bus.ram_raddr, 4'd1);
                4:   chk("raddr_col1_phase0", bus.ram_raddr, 4'd2);
                27:  chk("first_lat_cycle", first_lat, 10);
                60:  chk("raddr_msb_buf0", bus.ram_raddr[3], 1'b0);
                70:  bus.swap_req = 1'b1;
                110: chk("raddr_msb_buf1", bus.ram_raddr[3], 1'b1);
                157: bus.swap_req = 1'b0;
                230: bus.enable = 1'b0;
                283: begin
                    chk("reenable_raddr_col1", bus.ram_raddr, 4'd1);
                    chk("reenable_clk_low", bus.hub_clk, 1'b0);
                end
                284: chk("reenable_clk_high", bus.hub_clk, 1'b1);
                333: begin
                    chk("in_last_display", bus.hub_oe, 1'b0);
                    chk("last_display_row", bus.hub_row, 1'b1);
                    rst          = 1'b1;
                    bus.swap_req = 1'b1;
                end
                334: chk("reset_mid_display_outputs", 32'(outs()), 32'h10000);
                default: ;
            endcase
            if (k >= 261 && k <= 281) begin
                if (bus.hub_oe !== 1'b1) idle_oe_low++;
                if (bus.hub_lat !== 1'b0) idle_lat++;
            end
            if (k == 281) begin
                chk("idle_oe_low_cycles", idle_oe_low, 0);
                chk("idle_lat_pulses", idle_lat, 0);
                bus.enable = 1'b1;
            end
            if (k >= 334 && (bus.swap_ack !== 1'b0 || bus.buf_sel !== 1'b0 || bus.frame_done !== 1'b0))
                rst_events++;
            if (k == 337) chk("no_swap_under_reset", rst_events, 0);
            @(negedge clk);
        end

        chk("lat_events_all_seen", lat_q.size(), 0);
        chk("rgb_events_all_seen", rgb_q.size(), 0);
        chk("frame_done_all_seen", fd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
